// File: rtl/wormhole_port_scheduler_pkg.sv
// wormhole_port_scheduler_pkg
//   Shared constants for the per-output-port wormhole scheduler.
//   Holds the flit type codes, the input port indices (L, N, E, W, S),
//   the scheduler FSM state encoding and the default packet-length width.
package wormhole_port_scheduler_pkg;

  localparam int unsigned DEF_LEN_W = 12;

  // Flit type field, taken from FIFO data [31:29]
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  // Input port indices
  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned PORT_S = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } sched_state_e;

endpackage

// File: rtl/wormhole_port_scheduler_rr_pick.sv
// wormhole_port_scheduler_rr_pick (rr_pick)
//   Combinational round-robin priority selector. Returns the first set
//   candidate at or after ptr, searching upward and wrapping from N-1 to 0.
//   Reusable by any allocator that needs a rotating-priority pick.
// Ports:
//   cand  in  N      candidate request vector
//   ptr   in  PTR_W  highest-priority index (must be < N)
//   win   out N      one-hot winner, '0 when no candidate
//   valid out 1      a winner exists
module wormhole_port_scheduler_rr_pick #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             valid
);

  always_comb begin
    int unsigned      sum;
    logic [PTR_W-1:0] pos;
    win   = '0;
    valid = 1'b0;
    sum   = 0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= N) sum = sum - N;
      pos = PTR_W'(sum);
      if (!valid && cand[pos]) begin
        win[pos] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_port_scheduler.sv
// wormhole_port_scheduler
//   Wormhole round-robin scheduler for one router output port. Locks the
//   output to one input from header to tail (or until the length count
//   runs out) and drives the FIFO read grants and the crossbar select.
// Ports:
//   clk        in  1             router clock
//   rst        in  1             synchronous active-high reset
//   req        in  NPORTS        per-input ready toward this output
//   flit_type  in  3*NPORTS      per-input head flit type, port i at [3i+2:3i]
//   pkt_len    in  LEN_W*NPORTS  flits after the header, valid on header
//   dcts       in  1             downstream clear-to-send
//   grant      out NPORTS        one-hot read enable to the owning FIFO
//   sel        out NPORTS        one-hot crossbar select
//   busy       out 1             port locked to an owner
//   err        out 1             one-cycle pulse on protocol/timeout fault
// Build option:
//   SCHED_TIMEOUT_EN  adds a stall watchdog that drops the lock after
//                     TIMEOUT_CYCLES consecutive ungranted LOCK cycles.
module wormhole_port_scheduler
  import wormhole_port_scheduler_pkg::*;
#(
  parameter int unsigned NPORTS         = 5,
  parameter int unsigned LEN_W          = DEF_LEN_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req,
  input  logic [3*NPORTS-1:0]     flit_type,
  input  logic [LEN_W*NPORTS-1:0] pkt_len,
  input  logic                    dcts,
  output logic [NPORTS-1:0]       grant,
  output logic [NPORTS-1:0]       sel,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  sched_state_e     state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             err_q, err_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  logic [NPORTS-1:0] cand;
  logic [NPORTS-1:0] win_oh;
  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic [LEN_W-1:0]  win_len;
  logic [NPORTS-1:0] owner_oh;
  logic [2:0]        owner_ft;
  logic [PTR_W-1:0]  nxt_ptr;
  logic              grant_ok;

  // Header candidates and per-owner views; constant-index loops keep every
  // select static so no variable part-select width games are needed.
  always_comb begin
    cand     = '0;
    win_idx  = '0;
    win_len  = '0;
    owner_oh = '0;
    owner_ft = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      cand[i] = req[i] && (flit_type[3*i +: 3] == FLIT_HEADER);
      if (win_oh[i]) begin
        win_idx = PTR_W'(i);
        win_len = pkt_len[LEN_W*i +: LEN_W];
      end
      if (owner_q == PTR_W'(i)) begin
        owner_oh[i] = 1'b1;
        owner_ft    = flit_type[3*i +: 3];
      end
    end
  end

  wormhole_port_scheduler_rr_pick #(
    .N     (NPORTS),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .cand  (cand),
    .ptr   (rr_ptr_q),
    .win   (win_oh),
    .valid (win_valid)
  );

  assign nxt_ptr  = (owner_q == PTR_W'(NPORTS - 1)) ? '0 : owner_q + PTR_W'(1);
  // Grant depends only on registered ownership plus req/dcts, never on flit_type.
  assign grant_ok = (state_q == ST_LOCK) && ((req & owner_oh) != '0) && dcts;
  assign grant    = grant_ok ? owner_oh : '0;
  assign sel      = (state_q == ST_LOCK) ? owner_oh : '0;
  assign busy     = (state_q == ST_LOCK);
  assign err      = err_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    err_d    = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    stall_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          owner_d = win_idx;
          cnt_d   = {1'b0, win_len} + CNT_ONE;
          first_d = 1'b1;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (grant_ok) begin
          cnt_d   = cnt_q - CNT_ONE;
          first_d = 1'b0;
          // "cnt still at its initial value" is tracked by first_q
          if ((owner_ft == FLIT_HEADER) && !first_q) err_d = 1'b1;
          if ((cnt_q == CNT_ONE) || (owner_ft == FLIT_TAIL)) begin
            state_d  = ST_IDLE;
            rr_ptr_d = nxt_ptr;
          end
        end
`ifdef SCHED_TIMEOUT_EN
        else if (stall_q == STALL_LIMIT) begin
          state_d  = ST_IDLE;
          rr_ptr_d = nxt_ptr;
          err_d    = 1'b1;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      err_q    <= err_d;
`ifdef SCHED_TIMEOUT_EN
      stall_q  <= stall_d;
`endif
    end
  end

endmodule
